// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/pc_seq_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module pc_seq_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values in the same timestep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot, trap, branch redirect, stall and imem-wait arbitration.
// Define PC_SEQ_TRAP_EN to honour trap_i and capture epc_o.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned          ADDR_W       = 64,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0]    TRAP_VECTOR  = ADDR_W'('h100),
    parameter int unsigned          CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              fetch_ready_i,
    input  logic              trap_i,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              fetch_valid_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic [CNT_W-1:0]  redirect_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

`ifdef PC_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              misaligned;
    logic              redirect_inc;
    logic              stall_inc;

    assign misaligned = (branch_target_i[1:0] & ALIGN_MASK) != 2'b00;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        epc_d          = epc_q;
        pc_next_o      = pc_i;
        fetch_valid_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        misalign_o     = 1'b0;
        redirect_inc   = 1'b0;
        stall_inc      = 1'b0;

        unique case (state_q)
            BOOT: begin
                pc_next_o = RESET_VECTOR;
                state_d   = RUN;
            end
            RUN, WAIT: begin
                fetch_valid_o = 1'b1;
                misalign_o    = branch_taken_i && misaligned;
                // Redirects win over stall/wait; the held instruction is squashed by the flushes.
                if (TRAP_EN && (trap_i || (branch_taken_i && misaligned))) begin
                    pc_next_o     = TRAP_VECTOR;
                    epc_d         = pc_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    state_d       = RUN;
                end else if (branch_taken_i) begin
                    pc_next_o     = branch_target_i & ~ADDR_W'(ALIGN_MASK);
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    redirect_inc  = 1'b1;
                    state_d       = RUN;
                end else if (stall_i) begin
                    stall_inc = 1'b1;
                end else if (!fetch_ready_i) begin
                    stall_inc = 1'b1;
                    state_d   = WAIT;
                end else begin
                    pc_next_o = pc_i + ADDR_W'(INSTR_BYTES);
                    state_d   = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

    assign epc_o = epc_q;

    pc_seq_sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (redirect_inc),
        .count_o (redirect_cnt_o)
    );

    pc_seq_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stall_inc),
        .count_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed cases, random traffic, async reset mid-WAIT.
module tb_pc_sequencer;

    localparam int unsigned AW   = 64;
    localparam int unsigned SM_W = 3;
    localparam logic [63:0] RV   = 64'h0;
    localparam logic [63:0] TV   = 64'h100;

`ifdef PC_SEQ_TRAP_EN
    localparam bit TB_TRAP = 1'b1;
`else
    localparam bit TB_TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc_i = '0;
    logic          stall_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic [AW-1:0] branch_target_i = '0;
    logic          fetch_ready_i = 1'b1;
    logic          trap_i = 1'b0;

    logic [AW-1:0] pc_next_o, epc_o, s_pc_next, s_epc;
    logic          fetch_valid_o, flush_if_id_o, flush_id_ex_o, misalign_o;
    logic          s_fv, s_fif, s_fie, s_mis;
    logic [31:0]   redirect_cnt_o, stall_cnt_o;
    logic [SM_W-1:0] s_rc, s_sc;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .fetch_ready_i(fetch_ready_i), .trap_i(trap_i),
        .pc_next_o(pc_next_o), .fetch_valid_o(fetch_valid_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .misalign_o(misalign_o), .epc_o(epc_o),
        .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    pc_sequencer #(.CNT_W(SM_W)) u_small (
        .clk(clk), .reset(reset), .pc_i(pc_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .fetch_ready_i(fetch_ready_i), .trap_i(trap_i),
        .pc_next_o(s_pc_next), .fetch_valid_o(s_fv),
        .flush_if_id_o(s_fif), .flush_id_ex_o(s_fie),
        .misalign_o(s_mis), .epc_o(s_epc),
        .redirect_cnt_o(s_rc), .stall_cnt_o(s_sc)
    );

    typedef struct {
        logic [63:0] pc_next;
        logic        fv, flush, mis;
        logic [63:0] epc;
        logic [31:0] rc, sc;
        int unsigned rcs, scs;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state: the PC register, counters and epc as seen by software.
    logic [63:0] m_pc = '0;
    logic [63:0] m_epc = '0;
    logic [31:0] m_rc = '0, m_sc = '0;
    int unsigned m_rcs = 0, m_scs = 0;
    int unsigned sm_max = (1 << SM_W) - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_epc = '0; m_rc = '0; m_sc = '0; m_rcs = 0; m_scs = 0;
    endtask

    task automatic boot_cycle();
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b1;
        pc_i  = m_pc;
        e.pc_next = RV; e.fv = 1'b0; e.flush = 1'b0; e.mis = 1'b0;
        e.epc = m_epc; e.rc = m_rc; e.sc = m_sc; e.rcs = m_rcs; e.scs = m_scs;
        q.push_back(e);
        m_pc = RV;
    endtask

    task automatic step(input bit tr, input bit st, input bit br,
                        input logic [63:0] tgt, input bit rdy);
        exp_t        e;
        logic [63:0] nxt;
        bit          bad_align;
        @(posedge clk); #1;
        trap_i = tr; stall_i = st; branch_taken_i = br;
        branch_target_i = tgt; fetch_ready_i = rdy; pc_i = m_pc;

        bad_align = (tgt % 4) != 0;
        e.fv = 1'b1; e.flush = 1'b0; e.mis = br && bad_align;
        e.epc = m_epc; e.rc = m_rc; e.sc = m_sc; e.rcs = m_rcs; e.scs = m_scs;

        if (TB_TRAP && (tr || (br && bad_align))) begin
            nxt = TV; e.flush = 1'b1; m_epc = m_pc;
        end else if (br) begin
            nxt = tgt - (tgt % 4); e.flush = 1'b1;
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
            if (m_rcs < sm_max) m_rcs++;
        end else if (st || !rdy) begin
            nxt = m_pc;
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (m_scs < sm_max) m_scs++;
        end else begin
            nxt = m_pc + 64'd4;
        end
        e.pc_next = nxt;
        q.push_back(e);
        m_pc = nxt;
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #2;
        check("scoreboard_drained", 64'(q.size()), 64'd0);
    endtask

    // Monitor: pops one expectation per presented cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pc_next",     pc_next_o,       e.pc_next);
                check("fetch_valid", 64'(fetch_valid_o), 64'(e.fv));
                check("flush_if_id", 64'(flush_if_id_o), 64'(e.flush));
                check("flush_id_ex", 64'(flush_id_ex_o), 64'(e.flush));
                check("misalign",    64'(misalign_o),    64'(e.mis));
                check("epc",         epc_o,           e.epc);
                check("redirect_cnt", 64'(redirect_cnt_o), 64'(e.rc));
                check("stall_cnt",   64'(stall_cnt_o), 64'(e.sc));
                check("small_redirect_cnt", 64'(s_rc), 64'(e.rcs));
                check("small_stall_cnt",    64'(s_sc), 64'(e.scs));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tgt;
        repeat (3) @(posedge clk);
        boot_cycle();

        step(0, 0, 0, 64'h0, 1);                 // 0x0 -> 0x4

        m_pc = 64'h40;                            // three stall cycles at 0x40
        repeat (3) step(0, 1, 0, 64'h0, 1);
        step(0, 0, 0, 64'h0, 1);                 // stall_cnt now 3, pc 0x44

        m_pc = 64'h40;                            // redirect beats stall
        step(0, 1, 1, 64'h200, 1);
        step(0, 0, 0, 64'h0, 1);

        m_pc = 64'h80;                            // imem wait, then ready
        step(0, 0, 0, 64'h0, 0);
        step(0, 0, 0, 64'h0, 0);
        step(0, 0, 0, 64'h0, 1);

        m_pc = 64'h1000;                          // misaligned target
        step(0, 0, 1, 64'h202, 1);
        step(1, 0, 0, 64'h0, 1);                 // trap request (ignored unless enabled)

        m_pc = 64'hFFFF_FFFF_FFFF_FFFC;           // wrap to zero
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 0, 64'h0, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) m_pc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 31) == 0) m_pc = 64'hFFFF_FFFF_FFFF_FFF8;
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, tgt, $urandom_range(0, 3) != 0);
        end

        m_pc = 64'h80;                            // park in WAIT, then async reset
        step(0, 0, 0, 64'h0, 0);
        step(0, 0, 0, 64'h0, 0);
        drain();
        reset = 1'b0;
        #1;
        check("rst_fetch_valid", 64'(fetch_valid_o), 64'd0);
        check("rst_pc_next",     pc_next_o, RV);
        check("rst_flush_if_id", 64'(flush_if_id_o), 64'd0);
        check("rst_flush_id_ex", 64'(flush_id_ex_o), 64'd0);
        check("rst_misalign",    64'(misalign_o), 64'd0);
        check("rst_epc",         epc_o, 64'd0);
        check("rst_redirect_cnt", 64'(redirect_cnt_o), 64'd0);
        check("rst_stall_cnt",   64'(stall_cnt_o), 64'd0);
        check("rst_small_stall_cnt", 64'(s_sc), 64'd0);
        model_reset();
        m_pc = 64'h80;

        repeat (2) @(posedge clk);
        boot_cycle();
        step(0, 0, 0, 64'h0, 1);
        step(0, 1, 0, 64'h0, 1);
        step(0, 0, 1, 64'h3C, 1);
        step(0, 0, 0, 64'h0, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
